// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_LAP   = 2'd2,
    SW_PAUSE = 2'd3
  } sw_state_t;

  localparam logic [15:0] BCD_MAX = 16'h9999;
  localparam int TICK_DIV_DEFAULT = 500000;

endpackage

// File: rtl/stopwatch_ctrl_sw_edge.sv
// Rising-edge detector for an already-conditioned button level.
module sw_edge
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic press
);

  logic in_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_q <= 1'b0;
    else          in_q <= in;
  end

  assign press = in & ~in_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button FSM, count prescaler, lap freeze for the BCD chain.
// Optional build macro STOPWATCH_SATURATE_EN: stop at 99.99 instead of wrapping.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic [15:0] digits_in,
  output logic        adv,
  output logic        stp,
  output logic        clr,
  output logic [15:0] disp,
  output sw_state_t   state
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic          press_ss, press_ss_raw, press_lap, press_lap_raw;
  logic [PW-1:0] presc;
  logic [15:0]   lap_q;
  sw_state_t     state_nxt;
  logic          running, tick, adv_nxt, clr_nxt, cap;

  sw_edge u_edge_ss  (.clk(clk), .reset_n(reset_n), .in(btn_ss),  .press(press_ss_raw));
  sw_edge u_edge_lap (.clk(clk), .reset_n(reset_n), .in(btn_lap), .press(press_lap_raw));

  // Start/stop wins a same-cycle collision; the lap press is dropped.
  assign press_ss  = press_ss_raw;
  assign press_lap = press_lap_raw & ~press_ss_raw;

  assign running = (state == SW_RUN) || (state == SW_LAP);

  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    cap       = 1'b0;
    tick      = running && (presc == PRESC_MAX);
    adv_nxt   = tick;
    case (state)
      SW_IDLE: begin
        if (press_ss)       state_nxt = SW_RUN;
        else if (press_lap) clr_nxt   = 1'b1;
      end
      SW_RUN: begin
        if (press_ss) state_nxt = SW_PAUSE;
        else if (press_lap) begin
          state_nxt = SW_LAP;
          cap       = 1'b1;
        end
      end
      SW_LAP: begin
        if (press_ss)       state_nxt = SW_PAUSE;
        else if (press_lap) state_nxt = SW_RUN;
      end
      SW_PAUSE: begin
        if (press_ss) state_nxt = SW_RUN;
        else if (press_lap) begin
          state_nxt = SW_IDLE;
          clr_nxt   = 1'b1;
        end
      end
    endcase
`ifdef STOPWATCH_SATURATE_EN
    // Reaching 99.99 swallows the step that would wrap the chain and pauses.
    if (tick && (digits_in == BCD_MAX)) begin
      adv_nxt   = 1'b0;
      state_nxt = SW_PAUSE;
      cap       = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= SW_IDLE;
      presc <= '0;
      lap_q <= '0;
      adv   <= 1'b0;
      clr   <= 1'b0;
    end else begin
      state <= state_nxt;
      adv   <= adv_nxt;
      clr   <= clr_nxt;
      if (cap) lap_q <= digits_in;
      // Prescaler holds in pause so the sub-tick phase survives a stop/start.
      if (clr_nxt)      presc <= '0;
      else if (running) presc <= tick ? '0 : presc + PW'(1);
    end
  end

  assign stp  = (state == SW_IDLE) || (state == SW_PAUSE);
  assign disp = (state == SW_LAP) ? lap_q : digits_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV = 4.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_ss, btn_lap;
  logic [15:0] digits_in;
  logic        adv, stp, clr;
  logic [15:0] disp;
  sw_state_t   state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        ss;
    logic        lap;
    logic [15:0] dig;
    logic [1:0]  st;
    logic        stp;
    logic        adv;
    logic        clr;
    logic [15:0] disp;
  } vec_t;

  vec_t vecs[15];

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset_n(reset_n), .btn_ss(btn_ss), .btn_lap(btn_lap),
    .digits_in(digits_in), .adv(adv), .stp(stp), .clr(clr), .disp(disp),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Steps until adv is seen; n is the number of edges taken, -1 if none.
  task automatic measure_adv(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (adv) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;

    vecs[0]  = '{1'b0, 1'b1, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b1, 16'h0000};
    vecs[1]  = '{1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[8]  = '{1'b0, 1'b0, 16'h0123, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0123};
    vecs[9]  = '{1'b0, 1'b1, 16'h0123, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0123};
    vecs[10] = '{1'b0, 1'b1, 16'h0124, 2'd2, 1'b0, 1'b1, 1'b0, 16'h0123};
    vecs[11] = '{1'b0, 1'b0, 16'h0125, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0123};
    vecs[12] = '{1'b0, 1'b0, 16'h0126, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0123};
    vecs[13] = '{1'b0, 1'b1, 16'h0127, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0127};
    vecs[14] = '{1'b0, 1'b0, 16'h0128, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0128};

    reset_n = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; digits_in = 16'h0321;
    #2 reset_n = 1'b0;
    step(); step();
    chk("reset_state", 32'(state), 32'(SW_IDLE));
    chk("reset_stp", 32'(stp), 32'd1);
    chk("reset_adv", 32'(adv), 32'd0);
    chk("reset_clr", 32'(clr), 32'd0);
    chk("reset_disp", 32'(disp), 32'h0321);
    reset_n = 1'b1;

    digits_in = 16'h0000;
    cnt = 0;
    repeat (100) begin
      step();
      if (adv) cnt++;
    end
    chk("idle_adv_count", 32'(cnt), 32'd0);
    chk("idle_state", 32'(state), 32'(SW_IDLE));

    for (int i = 0; i < 15; i++) begin
      btn_ss = vecs[i].ss; btn_lap = vecs[i].lap; digits_in = vecs[i].dig;
      step();
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_stp", i), 32'(stp), 32'(vecs[i].stp));
      chk($sformatf("v%0d_adv", i), 32'(adv), 32'(vecs[i].adv));
      chk($sformatf("v%0d_clr", i), 32'(clr), 32'(vecs[i].clr));
      chk($sformatf("v%0d_disp", i), 32'(disp), 32'(vecs[i].disp));
    end

    // Pause two edges after an adv, resume later, phase must be kept.
    btn_ss = 1'b0; btn_lap = 1'b0;
    step();
    btn_ss = 1'b1;
    step();
    chk("pause_state", 32'(state), 32'(SW_PAUSE));
    chk("pause_stp", 32'(stp), 32'd1);
    btn_ss = 1'b0;
    cnt = 0;
    repeat (10) begin
      step();
      if (adv) cnt++;
    end
    chk("pause_adv_count", 32'(cnt), 32'd0);
    chk("pause_hold_state", 32'(state), 32'(SW_PAUSE));
    btn_ss = 1'b1;
    step();
    chk("resume_state", 32'(state), 32'(SW_RUN));
    btn_ss = 1'b0;
    measure_adv(8, n);
    chk("resume_adv_delay", 32'(n), 32'd2);

    // Pause then lap: back to idle with a one-cycle clear and a reset prescaler.
    btn_ss = 1'b1; step();
    btn_ss = 1'b0; step();
    btn_lap = 1'b1; step();
    chk("clr_state", 32'(state), 32'(SW_IDLE));
    chk("clr_pulse", 32'(clr), 32'd1);
    btn_lap = 1'b0; step();
    chk("clr_single", 32'(clr), 32'd0);
    chk("clr_idle", 32'(state), 32'(SW_IDLE));
    btn_ss = 1'b1; step();
    chk("restart_state", 32'(state), 32'(SW_RUN));
    btn_ss = 1'b0;
    measure_adv(8, n);
    chk("restart_adv_delay", 32'(n), 32'd4);

    // Simultaneous presses: start/stop wins in both directions.
    digits_in = 16'h0555;
    btn_ss = 1'b1; btn_lap = 1'b1; step();
    chk("both_run_state", 32'(state), 32'(SW_PAUSE));
    chk("both_run_clr", 32'(clr), 32'd0);
    btn_ss = 1'b0; btn_lap = 1'b0; step();
    btn_ss = 1'b1; btn_lap = 1'b1; step();
    chk("both_pause_state", 32'(state), 32'(SW_RUN));
    chk("both_pause_clr", 32'(clr), 32'd0);
    btn_ss = 1'b0; btn_lap = 1'b0; step();
    measure_adv(8, n);
    chk("both_adv_delay", 32'(n), 32'd2);

    // Asynchronous reset while adv is high.
    reset_n = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'(SW_IDLE));
    chk("async_adv", 32'(adv), 32'd0);
    chk("async_stp", 32'(stp), 32'd1);
    step();
    reset_n = 1'b1;

    // Running into 99.99.
    digits_in = 16'h9999;
    btn_ss = 1'b1; step();
    chk("sat_run", 32'(state), 32'(SW_RUN));
    btn_ss = 1'b0;
    cnt = 0;
    repeat (4) begin
      step();
      if (adv) cnt++;
    end
`ifdef STOPWATCH_SATURATE_EN
    chk("sat_adv_count", 32'(cnt), 32'd0);
    chk("sat_state", 32'(state), 32'(SW_PAUSE));
    chk("sat_stp", 32'(stp), 32'd1);
`else
    chk("wrap_adv_count", 32'(cnt), 32'd1);
    chk("wrap_state", 32'(state), 32'(SW_RUN));
    chk("wrap_stp", 32'(stp), 32'd0);
`endif
    chk("sat_disp", 32'(disp), 32'h9999);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
